// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit.
// Holds the condition-code and op encodings, the control state enum,
// the flag bit positions and the reset value of the flag register.
// Optional feature macro used elsewhere: BRU_PERF_CNT_EN (performance counters).
package bru_pkg;

   // Branch condition codes, evaluated against the {l,g,e} flag register
   localparam logic [2:0] COND_NEVER  = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_NE     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GT     = 3'b100;
   localparam logic [2:0] COND_LE     = 3'b101;
   localparam logic [2:0] COND_GE     = 3'b110;
   localparam logic [2:0] COND_ALWAYS = 3'b111;

   // Operation encoding on in_op
   localparam logic OP_CMP = 1'b0;
   localparam logic OP_BR  = 1'b1;

   // Flag bit indices inside the {l,g,e} vector
   localparam int unsigned FLAG_L = 2;
   localparam int unsigned FLAG_G = 1;
   localparam int unsigned FLAG_E = 0;

   // Flags come out of reset reporting "equal"
   localparam logic [2:0] FLAGS_RESET = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      WAIT = 2'd2
   } bru_state_e;

   // A legal comparator result has exactly one of l/g/e set
   function automatic logic is_one_hot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   cond  - 3-bit condition code (see bru_pkg COND_*)
//   flags - {l,g,e} flag register
//   taken - 1 when the condition holds for the given flags
module bru_cond_eval
   import bru_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       taken
);

   logic l, g, e;

   assign l = flags[FLAG_L];
   assign g = flags[FLAG_G];
   assign e = flags[FLAG_E];

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         COND_NEVER:  taken = 1'b0;
         COND_EQ:     taken = e;
         COND_NE:     taken = ~e;
         COND_LT:     taken = l;
         COND_GT:     taken = g;
         COND_LE:     taken = l | e;
         COND_GE:     taken = g | e;
         COND_ALWAYS: taken = 1'b1;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage downstream of the 16-bit magnitude comparator.
// CMP ops latch a one-hot {less,greater,equal} result into the flag register
// (non-one-hot results set the sticky flag_err instead). BR ops are evaluated
// one cycle later against the flags; a taken branch raises a redirect that is
// held until fetch accepts it.
// Optional feature: define BRU_PERF_CNT_EN to enable the saturating
// br_cnt / taken_cnt performance counters; otherwise they read as zero.
// Ports:
//   clk, rst                     - clock, async active-high reset
//   in_valid/in_ready            - operation handshake (ready only in IDLE)
//   in_op                        - 0 = CMP, 1 = BR
//   less/greater/equal           - comparator result, sampled on accepted CMP
//   cond, br_target              - branch condition/target, sampled on accepted BR
//   redirect_valid/ready/pc      - PC redirect handshake to fetch
//   br_done, br_taken            - one-cycle resolve pulse and its outcome
//   flags, flag_err              - {l,g,e} flag register, sticky illegal-flag bit
//   taken_cnt, br_cnt            - performance counters
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int PC_W  = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic             less,
   input  logic             greater,
   input  logic             equal,
   input  logic [2:0]       cond,
   input  logic [PC_W-1:0]  br_target,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             br_done,
   output logic             br_taken,
   output logic [2:0]       flags,
   output logic             flag_err,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] br_cnt
);

   bru_state_e      state_q, state_d;
   logic [2:0]      flags_q;
   logic            flag_err_q;
   logic [2:0]      cond_q;
   logic [PC_W-1:0] target_q;
   logic            br_done_q, br_taken_q;
   logic            redirect_valid_q;
   logic [PC_W-1:0] redirect_pc_q;

   logic            accept_cmp, accept_br;
   logic            in_eval;
   logic            taken;
   logic [2:0]      cmp_vec;

   assign in_ready   = (state_q == IDLE);
   assign accept_cmp = in_valid && in_ready && (in_op == OP_CMP);
   assign accept_br  = in_valid && in_ready && (in_op == OP_BR);
   assign in_eval    = (state_q == EVAL);
   assign cmp_vec    = {less, greater, equal};

   // Flags cannot change while a BR is in EVAL, since CMPs are only taken in IDLE
   bru_cond_eval u_cond_eval (
      .cond  (cond_q),
      .flags (flags_q),
      .taken (taken)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept_br) state_d = EVAL;
         EVAL:    state_d = taken ? WAIT : IDLE;
         WAIT:    if (redirect_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         flags_q          <= FLAGS_RESET;
         flag_err_q       <= 1'b0;
         cond_q           <= COND_NEVER;
         target_q         <= '0;
         br_done_q        <= 1'b0;
         br_taken_q       <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q <= state_d;

         if (accept_cmp) begin
            if (is_one_hot3(cmp_vec)) begin
               flags_q <= cmp_vec;
            end else begin
               flag_err_q <= 1'b1;
            end
         end

         if (accept_br) begin
            cond_q   <= cond;
            target_q <= br_target;
         end

         // Resolve outputs are registered: they appear the cycle after EVAL
         br_done_q  <= in_eval;
         br_taken_q <= in_eval && taken;

         if (in_eval && taken) begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_q;
         end else if ((state_q == WAIT) && redirect_ready) begin
            redirect_valid_q <= 1'b0;
         end
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign br_done        = br_done_q;
   assign br_taken       = br_taken_q;
   assign flags          = flags_q;
   assign flag_err       = flag_err_q;

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] br_cnt_q, taken_cnt_q;

   // Counted on the edge that raises br_done, so they line up with the pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else if (in_eval) begin
         if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
         if (taken && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + 1'b1;
      end
   end

   assign br_cnt    = br_cnt_q;
   assign taken_cnt = taken_cnt_q;
`else
   assign br_cnt    = '0;
   assign taken_cnt = '0;
`endif

endmodule
